// File: rtl/mc_rb_fuse_skew_seq.sv
// Fuse skew-write sequencer: on a fuse capture, sweeps addresses 1..last on
// every enabled channel in ascending order, then pulses done.
module mc_rb_fuse_skew_seq #(
  parameter int ADDR_W = 5,
  parameter int NUM_CH = 2,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              mc_rb_ef1_sclk_i,
  input  logic              gctl_rclk_orst_n_i,
  input  logic              mc_rb_ef1_svld_i,
  input  logic              mc_rb_fuse_vld_i,
  input  logic [ADDR_W-1:0] cfg_last_addr_i,
  input  logic [NUM_CH-1:0] cfg_ch_en_i,
  output logic [ADDR_W-1:0] skew_addr_cntr_o,
  output logic [CH_W-1:0]   skew_ch_o,
  output logic              skew_wr_en_o,
  output logic              skew_busy_o,
  output logic              skew_done_o,
  output logic              skew_ovr_err_o
);

  typedef enum logic {IDLE, SWEEP} state_e;

  state_e            state_q, state_d;
  logic              fuse_vld_q, capture;
  logic [ADDR_W-1:0] last_q, last_d, addr_d;
  logic [NUM_CH-1:0] en_q, en_d;
  logic [CH_W-1:0]   ch_d, first_ch, nxt_ch;
  logic              has_nxt, wr_en_d, busy_d, done_d, ovr_d;

  assign capture = ~mc_rb_ef1_svld_i & fuse_vld_q;

  // First channel comes from the live mask (used only at sweep start);
  // the advance search uses the mask latched for the in-flight sweep.
  always_comb begin
    first_ch = '0;
    nxt_ch   = '0;
    has_nxt  = 1'b0;
    for (int i = NUM_CH-1; i >= 0; i--) begin
      if (cfg_ch_en_i[i]) first_ch = CH_W'(i);
      if (en_q[i] && (CH_W'(i) > skew_ch_o)) begin
        nxt_ch  = CH_W'(i);
        has_nxt = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    en_d    = en_q;
    addr_d  = '0;
    ch_d    = '0;
    wr_en_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    ovr_d   = skew_ovr_err_o;
    unique case (state_q)
      IDLE: begin
        if (capture) begin
          if ((cfg_ch_en_i != '0) && (cfg_last_addr_i != '0)) begin
            state_d = SWEEP;
            last_d  = cfg_last_addr_i;
            en_d    = cfg_ch_en_i;
            addr_d  = ADDR_W'(1);
            ch_d    = first_ch;
            wr_en_d = 1'b1;
            busy_d  = 1'b1;
          end else begin
            done_d  = 1'b1;
          end
        end
      end
      SWEEP: begin
        if (capture) ovr_d = 1'b1;
        wr_en_d = 1'b1;
        busy_d  = 1'b1;
        if (skew_addr_cntr_o != last_q) begin
          addr_d = skew_addr_cntr_o + ADDR_W'(1);
          ch_d   = skew_ch_o;
        end else if (has_nxt) begin
          addr_d = ADDR_W'(1);
          ch_d   = nxt_ch;
        end else begin
          state_d = IDLE;
          wr_en_d = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge mc_rb_ef1_sclk_i or negedge gctl_rclk_orst_n_i) begin
    if (!gctl_rclk_orst_n_i) begin
      fuse_vld_q       <= 1'b0;
      state_q          <= IDLE;
      last_q           <= '0;
      en_q             <= '0;
      skew_addr_cntr_o <= '0;
      skew_ch_o        <= '0;
      skew_wr_en_o     <= 1'b0;
      skew_busy_o      <= 1'b0;
      skew_done_o      <= 1'b0;
      skew_ovr_err_o   <= 1'b0;
    end else begin
      fuse_vld_q       <= mc_rb_fuse_vld_i;
      state_q          <= state_d;
      last_q           <= last_d;
      en_q             <= en_d;
      skew_addr_cntr_o <= addr_d;
      skew_ch_o        <= ch_d;
      skew_wr_en_o     <= wr_en_d;
      skew_busy_o      <= busy_d;
      skew_done_o      <= done_d;
      skew_ovr_err_o   <= ovr_d;
    end
  end

endmodule
